// File: rtl/pc_stack_unit_if.sv
// Decoder-side bundle for the PC/stack unit.
// Carries opcode, operand, flags and status back out.
interface pc_stack_unit_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 8
);
    localparam int CW = $clog2(STACK_DEPTH) + 1;

    logic                  pc_enable;
    logic [DATA_WIDTH-1:0] opcode;
    logic [DATA_WIDTH-1:0] operand;
    logic [3:0]            flags;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] pc_debug_output;
    logic [CW-1:0]         stack_count;
    logic                  stack_overflow;
    logic                  stack_underflow;
    logic                  halted;

    modport master (
        output pc_enable, opcode, operand,
        output flags, read_enable,
        input  pc_debug_output, stack_count,
        input  stack_overflow, stack_underflow,
        input  halted
    );

    modport slave (
        input  pc_enable, opcode, operand,
        input  flags, read_enable,
        output pc_debug_output, stack_count,
        output stack_overflow, stack_underflow,
        output halted
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with return-address stack and HALT.
// Define PC_STACK_TRAP_EN to vector stack errors to TRAP_VECTOR.
module pc_stack_unit #(
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 8
`ifdef PC_STACK_TRAP_EN
    ,
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = '1
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    pc_stack_unit_if.slave        bus,
    output tri [DATA_WIDTH-1:0]   pc
);
    localparam int CW = $clog2(STACK_DEPTH) + 1;
    localparam int PW = $clog2(STACK_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(STACK_DEPTH);

    typedef enum logic {RUN, HALT} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [CW-1:0]         cnt;
    logic                  ovf;
    logic                  unf;
    logic [DATA_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [3:0]            sel;
    logic [3:0]            op;
    logic [DATA_WIDTH-1:0] pc_inc;
    logic [DATA_WIDTH-1:0] pc_rel;
    logic [DATA_WIDTH-1:0] pc_n;
    logic [DATA_WIDTH-1:0] top_val;
    logic [PW-1:0]         push_idx;
    logic [PW-1:0]         pop_idx;
    logic                  carry;
    logic                  zero;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  ovf_set;
    logic                  unf_set;
    logic                  go_halt;
    logic                  adv;

    assign sel      = bus.opcode[DATA_WIDTH-1 -: 4];
    assign op       = bus.opcode[DATA_WIDTH-5 -: 4];
    assign carry    = bus.flags[1];
    assign zero     = bus.flags[0];
    assign pc_inc   = pc_q + 1'b1;
    assign pc_rel   = pc_q + bus.operand;
    assign full     = (cnt == FULL);
    assign empty    = (cnt == '0);
    assign push_idx = cnt[PW-1:0];
    assign pop_idx  = PW'(cnt - 1'b1);
    assign top_val  = stack_mem[pop_idx];
    assign adv      = bus.pc_enable && (state == RUN);

    always_comb begin
        pc_n    = pc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        go_halt = 1'b0;
        if (sel == 4'b0111) begin
            case (op)
                4'h0: pc_n = bus.operand;
                4'h1: pc_n = carry ? bus.operand : pc_inc;
                4'h2: pc_n = zero ? bus.operand : pc_inc;
                4'h3: pc_n = pc_rel;
                4'h4: pc_n = carry ? pc_rel : pc_inc;
                4'h5: pc_n = zero ? pc_rel : pc_inc;
                4'h6: pc_n = !zero ? bus.operand : pc_inc;
                4'h7, 4'h8: begin
                    pc_n = (op == 4'h7) ? bus.operand : pc_rel;
                    if (full) begin
                        ovf_set = 1'b1;
`ifdef PC_STACK_TRAP_EN
                        pc_n = TRAP_VECTOR;
`endif
                    end else begin
                        push = 1'b1;
                    end
                end
                4'h9: begin
                    if (empty) begin
                        unf_set = 1'b1;
`ifdef PC_STACK_TRAP_EN
                        pc_n = TRAP_VECTOR;
`endif
                    end else begin
                        pop  = 1'b1;
                        pc_n = top_val;
                    end
                end
                4'hF: begin
                    pc_n    = pc_q;
                    go_halt = 1'b1;
                end
                default: pc_n = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc_q  <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (adv) begin
            pc_q <= pc_n;
            ovf  <= ovf | ovf_set;
            unf  <= unf | unf_set;
            if (push)
                cnt <= cnt + 1'b1;
            else if (pop)
                cnt <= cnt - 1'b1;
            if (go_halt)
                state <= HALT;
        end
    end

    // Stack storage needs no reset; only entries below cnt are ever read.
    always_ff @(posedge clk) begin
        if (!reset && adv && push)
            stack_mem[push_idx] <= pc_inc;
    end

    assign pc                  = bus.read_enable ? pc_q : 'z;
    assign bus.pc_debug_output = pc_q;
    assign bus.stack_count     = cnt;
    assign bus.stack_overflow  = ovf;
    assign bus.stack_underflow = unf;
    assign bus.halted          = (state == HALT);
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed test of pc_stack_unit with a 4-entry stack.
// Expected values are hand-computed per vector.
module tb_pc_stack_unit;
    localparam int DW = 16;
    localparam int SD = 4;
    localparam logic [15:0] TRAP = 16'hFFFF;

    logic clk = 1'b0;
    logic reset;
    tri1 [DW-1:0] pc_bus;
    int n_chk = 0;
    int n_pass = 0;

    pc_stack_unit_if #(.DATA_WIDTH(DW), .STACK_DEPTH(SD)) ifc ();

    pc_stack_unit #(.DATA_WIDTH(DW), .STACK_DEPTH(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc),
        .pc    (pc_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic [15:0] opc,
                        input logic [15:0] opr);
        ifc.opcode  = opc;
        ifc.operand = opr;
        @(posedge clk);
        #1;
    endtask

    task automatic jmp(input logic [15:0] tgt);
        step(16'h7000, tgt);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [15:0] cond_op [6];
    logic [3:0]  cond_fl [6];
    logic [15:0] cond_ex [6];
    logic [15:0] ovf_pc;
    logic [15:0] unf_pc;

    initial begin
        ifc.pc_enable   = 1'b1;
        ifc.opcode      = 16'h1000;
        ifc.operand     = 16'h0000;
        ifc.flags       = 4'b0000;
        ifc.read_enable = 1'b0;
        reset           = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_pc", 32'(ifc.pc_debug_output), 32'h0);
        chk("rst_cnt", 32'(ifc.stack_count), 32'h0);
        chk("rst_ovf", 32'(ifc.stack_overflow), 32'h0);
        chk("rst_unf", 32'(ifc.stack_underflow), 32'h0);
        chk("rst_halt", 32'(ifc.halted), 32'h0);

        for (int i = 0; i < 5; i++)
            step(16'h1000, 16'h0000);
        chk("inc5", 32'(ifc.pc_debug_output), 32'h5);
        chk("bus_off", 32'(pc_bus), 32'hFFFF);
        ifc.read_enable = 1'b1;
        #1;
        chk("bus_on", 32'(pc_bus), 32'h5);
        ifc.read_enable = 1'b0;

        jmp(16'h0010);
        step(16'h7300, 16'hFFFC);
        chk("rel_back", 32'(ifc.pc_debug_output), 32'h000C);
        jmp(16'h0002);
        step(16'h7300, 16'hFFFC);
        chk("rel_wrap", 32'(ifc.pc_debug_output), 32'hFFFE);
        step(16'h7300, 16'h0000);
        chk("rel_self", 32'(ifc.pc_debug_output), 32'hFFFE);

        jmp(16'h0020);
        step(16'h7700, 16'h0100);
        chk("call1_pc", 32'(ifc.pc_debug_output), 32'h0100);
        chk("call1_cnt", 32'(ifc.stack_count), 32'h1);
        step(16'h7700, 16'h0200);
        chk("call2_pc", 32'(ifc.pc_debug_output), 32'h0200);
        chk("call2_cnt", 32'(ifc.stack_count), 32'h2);
        step(16'h7900, 16'h0000);
        chk("ret1_pc", 32'(ifc.pc_debug_output), 32'h0101);
        chk("ret1_cnt", 32'(ifc.stack_count), 32'h1);
        step(16'h7900, 16'h0000);
        chk("ret2_pc", 32'(ifc.pc_debug_output), 32'h0021);
        chk("ret2_cnt", 32'(ifc.stack_count), 32'h0);

        ifc.pc_enable = 1'b0;
        step(16'h7700, 16'h1234);
        chk("hold_pc", 32'(ifc.pc_debug_output), 32'h0021);
        chk("hold_cnt", 32'(ifc.stack_count), 32'h0);
        ifc.pc_enable = 1'b1;

        jmp(16'h0100);
        step(16'h7800, 16'h0010);
        chk("crel_pc", 32'(ifc.pc_debug_output), 32'h0110);
        chk("crel_cnt", 32'(ifc.stack_count), 32'h1);
        step(16'h7900, 16'h0000);
        chk("crel_ret", 32'(ifc.pc_debug_output), 32'h0101);

`ifdef PC_STACK_TRAP_EN
        ovf_pc = TRAP;
        unf_pc = TRAP;
`else
        ovf_pc = 16'h0050;
        unf_pc = 16'h0002;
`endif
        jmp(16'h0000);
        step(16'h7700, 16'h0010);
        step(16'h7700, 16'h0020);
        step(16'h7700, 16'h0030);
        step(16'h7700, 16'h0040);
        chk("fill_cnt", 32'(ifc.stack_count), 32'h4);
        chk("fill_ovf", 32'(ifc.stack_overflow), 32'h0);
        step(16'h7700, 16'h0050);
        chk("ovf_pc", 32'(ifc.pc_debug_output), 32'(ovf_pc));
        chk("ovf_cnt", 32'(ifc.stack_count), 32'h4);
        chk("ovf_flag", 32'(ifc.stack_overflow), 32'h1);
        step(16'h7900, 16'h0000);
        chk("pop4", 32'(ifc.pc_debug_output), 32'h0031);
        step(16'h7900, 16'h0000);
        chk("pop3", 32'(ifc.pc_debug_output), 32'h0021);
        step(16'h7900, 16'h0000);
        chk("pop2", 32'(ifc.pc_debug_output), 32'h0011);
        step(16'h7900, 16'h0000);
        chk("pop1", 32'(ifc.pc_debug_output), 32'h0001);
        chk("pop_unf0", 32'(ifc.stack_underflow), 32'h0);
        step(16'h7900, 16'h0000);
        chk("unf_pc", 32'(ifc.pc_debug_output), 32'(unf_pc));
        chk("unf_cnt", 32'(ifc.stack_count), 32'h0);
        chk("unf_flag", 32'(ifc.stack_underflow), 32'h1);
        chk("ovf_sticky", 32'(ifc.stack_overflow), 32'h1);

        cond_op = '{16'h7100, 16'h7200, 16'h7600,
                    16'h7400, 16'h7500, 16'h7600};
        cond_fl = '{4'b0010, 4'b0010, 4'b0010,
                    4'b0010, 4'b0010, 4'b0001};
        cond_ex = '{16'h0040, 16'h0061, 16'h0040,
                    16'h00A0, 16'h0061, 16'h0061};
        for (int i = 0; i < 6; i++) begin
            jmp(16'h0060);
            ifc.flags = cond_fl[i];
            step(cond_op[i], 16'h0040);
            chk($sformatf("cond%0d", i),
                32'(ifc.pc_debug_output), 32'(cond_ex[i]));
        end
        ifc.flags = 4'b0001;
        jmp(16'h0060);
        step(16'h7100, 16'h0040);
        chk("jmpc_nt", 32'(ifc.pc_debug_output), 32'h0061);
        jmp(16'h0060);
        step(16'h7200, 16'h0040);
        chk("jmpz_t", 32'(ifc.pc_debug_output), 32'h0040);
        ifc.flags = 4'b0000;

        jmp(16'h0070);
        step(16'h7A00, 16'h1234);
        chk("undef_op", 32'(ifc.pc_debug_output), 32'h0071);

        jmp(16'h0033);
        step(16'h7F00, 16'h0000);
        chk("halt_pc", 32'(ifc.pc_debug_output), 32'h0033);
        chk("halt_flag", 32'(ifc.halted), 32'h1);
        for (int i = 0; i < 10; i++)
            jmp(16'h1234);
        step(16'h7700, 16'h0500);
        chk("halt_hold", 32'(ifc.pc_debug_output), 32'h0033);
        chk("halt_cnt", 32'(ifc.stack_count), 32'h0);
        chk("halt_stay", 32'(ifc.halted), 32'h1);

        ifc.opcode = 16'h7700;
        do_reset();
        chk("rst2_pc", 32'(ifc.pc_debug_output), 32'h0);
        chk("rst2_halt", 32'(ifc.halted), 32'h0);
        chk("rst2_ovf", 32'(ifc.stack_overflow), 32'h0);
        chk("rst2_unf", 32'(ifc.stack_underflow), 32'h0);
        chk("rst2_cnt", 32'(ifc.stack_count), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
